cnn_layer_sequencer: RTL and testbench
======================================

# cnn_layer_sequencer

Parametrised, fully synchronous layer sequencer for the systolic CNN accelerator. It holds a run-time-programmable per-layer configuration table, steps through `num_layers` layers, and hands each layer's parameters plus a one-cycle `start_layer` pulse to the datapath. It collects `done_layer` from the datapath and raises `done_CNN` once the last layer has finished. It replaces hard-coded layer schedules and adds table programming, abort, and busy/error status.

## Interface
- `MAX_LAYERS`, default 16: depth of the configuration table.
- `ADDR_W`, default 22: width of the OFM RAM address fields.
- `CFG_W`, fixed at 37+2*ADDR_W: width of one table entry (derived; not overridable).
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cfg_we`  in  1  table write strobe.
- `cfg_idx`  in  $clog2(MAX_LAYERS)  table entry being written.
- `cfg_wdata`  in  CFG_W  packed entry, LSB first:
  - [8:0] ifm_size; [19:9] ifm_channel; [21:20] kernel_size; [32:22] num_filter;
  - [33] maxpool_mode; [35:34] maxpool_stride; [36] upsample_mode;
  - [36+ADDR_W:37] start_write_addr; [36+2*ADDR_W:37+ADDR_W] start_read_addr.
- `num_layers`  in  $clog2(MAX_LAYERS+1)  layers in the run; sampled with `start_CNN`.
- `start_CNN`  in  1  level or pulse; sampled only in IDLE.
- `abort`  in  1  synchronous run abort.
- `done_layer`  in  1  one-cycle pulse from the datapath.
- `start_layer`  out  1  one-cycle pulse, one per layer.
- `done_CNN`  out  1  one-cycle pulse at run end.
- `busy`  out  1  high in any state other than IDLE.
- `cfg_err`  out  1  one-cycle pulse when a write is dropped.
- `count_layer`  out  $clog2(MAX_LAYERS+1)  1-based number of the current layer; 0 when idle.
- Configuration outputs, all registered: `ifm_size`[9], `ifm_channel`[11], `kernel_size`[2], `num_filter`[11], `maxpool_mode`[1], `maxpool_stride`[2], `upsample_mode`[1], `start_write_addr`[ADDR_W], `start_read_addr`[ADDR_W].

## Operation
- **States:** IDLE, LOAD, START, RUN.
- **Reset values:**
  - State IDLE.
  - All outputs 0.
  - Table entries 0; run length register 0.
- **Table writes:**
  - A write with `cfg_we`=1 while `busy`=0 and `cfg_idx`<MAX_LAYERS updates the entry at the clock edge.
  - A write is dropped, with a `cfg_err` pulse on the next cycle, if `busy`=1 or `cfg_idx`>=MAX_LAYERS.
  - A write in the same cycle that `start_CNN` is accepted is not dropped. The table read in LOAD sees the new data.
- **IDLE:**
  - On `start_CNN`=1, latch min(`num_layers`, MAX_LAYERS) as the run length and clear the layer index.
  - If the run length is 0: pulse `done_CNN` next cycle and stay in IDLE.
  - Otherwise: go to LOAD.
- **LOAD:**
  - Register the entry at the current index onto the configuration outputs.
  - `count_layer` <= index+1.
  - Go to START.
- **START:**
  - Assert `start_layer` for exactly one cycle.
  - Go to RUN.
- **RUN:**
  - Wait for `done_layer`.
  - If the index equals run length−1: pulse `done_CNN`, go to IDLE, and clear `count_layer` to 0. Configuration outputs hold their last values.
  - Otherwise: index+1, go to LOAD.
- **Spurious handshakes:**
  - `done_layer` outside RUN is ignored.
  - `start_CNN` outside IDLE is ignored.
- **abort:**
  - In any non-IDLE state, go to IDLE next edge and clear `count_layer`.
  - No `done_CNN` is issued.
  - A `start_layer` that would have fired that edge is suppressed.
  - `abort` has priority over a simultaneous `done_layer`.
- **Reset mid-run:** returns immediately to reset values. The table is also cleared, so software must reprogram it.

## Timing
- Edge E0 samples `start_CNN`.
- Configuration outputs are valid after E1.
- `start_layer` is high for the cycle after E2. Configuration is therefore stable at least one full cycle before `start_layer`.
- Edge En samples `done_layer` in RUN:
  - Non-last layer: next-layer configuration valid after En+1; `start_layer` high after En+2. Inter-layer overhead is 2 cycles.
  - Last layer: `done_CNN` high for the cycle after En; `busy` falls at the same edge.
- Configuration outputs never change while in RUN.

## Test plan
- **3-layer run:** program entries 0..2, `num_layers`=3, pulse `start_CNN`, return `done_layer` 5 cycles after each `start_layer` → exactly 3 `start_layer` pulses, each 2 edges after start/done. `count_layer` goes 1,2,3. Outputs match entries 0..2. One `done_CNN` pulse, then `busy`=0.
- **Empty run:** `num_layers`=0 with `start_CNN` → `done_CNN` pulse next cycle, no `start_layer`, `busy` stays 0.
- **Clamping:** `num_layers`=MAX_LAYERS+3 (16-deep table) → exactly 16 `start_layer` pulses.
- **Abort:** `abort` during layer 2 RUN, coincident with `done_layer` → IDLE next edge, `count_layer`=0, no `done_CNN`. A subsequent `start_CNN` restarts from layer 1.
- **Dropped writes:** `cfg_we` while `busy` → `cfg_err` pulse, entry unchanged when read back in a later run. `cfg_idx`=MAX_LAYERS while idle → `cfg_err` pulse.
- **Spurious handshakes and reset:** `done_layer` pulsed in IDLE/LOAD/START → ignored, no index advance. `rst_n` low mid-RUN → all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/cnn_layer_sequencer.sv
// Layer sequencer for the systolic CNN accelerator: holds a programmable per-layer
// config table and steps the datapath through one layer at a time.
module cnn_layer_sequencer #(
  parameter int  MAX_LAYERS = 16,
  parameter int  ADDR_W     = 22,
  localparam int CFG_W      = 37 + 2*ADDR_W,
  localparam int IDX_W      = $clog2(MAX_LAYERS),
  localparam int CNT_W      = $clog2(MAX_LAYERS+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [CFG_W-1:0]  cfg_wdata,
  input  logic [CNT_W-1:0]  num_layers,
  input  logic              start_CNN,
  input  logic              abort,
  input  logic              done_layer,
  output logic              start_layer,
  output logic              done_CNN,
  output logic              busy,
  output logic              cfg_err,
  output logic [CNT_W-1:0]  count_layer,
  output logic [8:0]        ifm_size,
  output logic [10:0]       ifm_channel,
  output logic [1:0]        kernel_size,
  output logic [10:0]       num_filter,
  output logic              maxpool_mode,
  output logic [1:0]        maxpool_stride,
  output logic              upsample_mode,
  output logic [ADDR_W-1:0] start_write_addr,
  output logic [ADDR_W-1:0] start_read_addr
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_START = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  logic [1:0]       state;
  logic [CFG_W-1:0] tbl [MAX_LAYERS];
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] run_len, clamp_len;
  logic [CFG_W-1:0] ent;
  logic             idx_ok, wr_ok, last;

  assign busy      = (state != S_IDLE);
  assign idx_ok    = 32'(cfg_idx) < MAX_LAYERS;
  assign wr_ok     = cfg_we && !busy && idx_ok;
  assign clamp_len = (32'(num_layers) > MAX_LAYERS) ? CNT_W'(MAX_LAYERS) : num_layers;
  assign last      = (32'(idx) + 32'd1 == 32'(run_len));
  assign ent       = tbl[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      idx              <= '0;
      run_len          <= '0;
      start_layer      <= 1'b0;
      done_CNN         <= 1'b0;
      cfg_err          <= 1'b0;
      count_layer      <= '0;
      ifm_size         <= '0;
      ifm_channel      <= '0;
      kernel_size      <= '0;
      num_filter       <= '0;
      maxpool_mode     <= 1'b0;
      maxpool_stride   <= '0;
      upsample_mode    <= 1'b0;
      start_write_addr <= '0;
      start_read_addr  <= '0;
      for (int i = 0; i < MAX_LAYERS; i++) tbl[i] <= '0;
    end else begin
      start_layer <= 1'b0;
      done_CNN    <= 1'b0;
      cfg_err     <= cfg_we && !wr_ok;
      // a write landing with the accepted start is visible to the LOAD read next cycle
      if (wr_ok) tbl[cfg_idx] <= cfg_wdata;
      case (state)
        S_IDLE: if (start_CNN) begin
          idx     <= '0;
          run_len <= clamp_len;
          if (clamp_len == '0) done_CNN <= 1'b1;
          else                 state    <= S_LOAD;
        end
        S_LOAD: if (abort) begin
          state       <= S_IDLE;
          count_layer <= '0;
        end else begin
          ifm_size         <= ent[8:0];
          ifm_channel      <= ent[19:9];
          kernel_size      <= ent[21:20];
          num_filter       <= ent[32:22];
          maxpool_mode     <= ent[33];
          maxpool_stride   <= ent[35:34];
          upsample_mode    <= ent[36];
          start_write_addr <= ent[36+ADDR_W:37];
          start_read_addr  <= ent[36+2*ADDR_W:37+ADDR_W];
          count_layer      <= CNT_W'(32'(idx) + 32'd1);
          state            <= S_START;
        end
        S_START: if (abort) begin
          state       <= S_IDLE;
          count_layer <= '0;
        end else begin
          start_layer <= 1'b1;
          state       <= S_RUN;
        end
        S_RUN: if (abort) begin
          state       <= S_IDLE;
          count_layer <= '0;
        end else if (done_layer) begin
          if (last) begin
            done_CNN    <= 1'b1;
            count_layer <= '0;
            state       <= S_IDLE;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Randomized bench for cnn_layer_sequencer: table/run model plus pulse timing scoreboard.
module tb_cnn_layer_sequencer;
  localparam int ML = 16;
  localparam int AW = 22;
  localparam int CW = 37 + 2*AW;
  localparam int IW = 4;
  localparam int NW = 5;

  logic clk = 0, rst_n = 0, cfg_we = 0, start_CNN = 0, abort = 0, done_layer = 0;
  logic [IW-1:0] cfg_idx = '0;
  logic [CW-1:0] cfg_wdata = '0;
  logic [NW-1:0] num_layers = '0;
  logic start_layer, done_CNN, busy, cfg_err;
  logic [NW-1:0] count_layer;
  logic [8:0] ifm_size; logic [10:0] ifm_channel, num_filter; logic [1:0] kernel_size, maxpool_stride;
  logic maxpool_mode, upsample_mode; logic [AW-1:0] start_write_addr, start_read_addr;
  logic [CW-1:0] cfg_pack;

  // second instance with a non-power-of-two table so an out-of-range index is expressible
  logic cfg_we2 = 0; logic [3:0] cfg_idx2 = '0; logic [3:0] num2 = '0;
  logic d2_sl, d2_dc, d2_busy, d2_err; logic [3:0] d2_cnt;
  logic [8:0] d2_a; logic [10:0] d2_b, d2_d; logic [1:0] d2_c, d2_f; logic d2_e, d2_g;
  logic [AW-1:0] d2_h, d2_i;

  always #5 clk = ~clk;

  cnn_layer_sequencer #(.MAX_LAYERS(ML), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_wdata(cfg_wdata),
    .num_layers(num_layers), .start_CNN(start_CNN), .abort(abort), .done_layer(done_layer),
    .start_layer(start_layer), .done_CNN(done_CNN), .busy(busy), .cfg_err(cfg_err),
    .count_layer(count_layer), .ifm_size(ifm_size), .ifm_channel(ifm_channel),
    .kernel_size(kernel_size), .num_filter(num_filter), .maxpool_mode(maxpool_mode),
    .maxpool_stride(maxpool_stride), .upsample_mode(upsample_mode),
    .start_write_addr(start_write_addr), .start_read_addr(start_read_addr));

  cnn_layer_sequencer #(.MAX_LAYERS(12), .ADDR_W(AW)) dut2 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we2), .cfg_idx(cfg_idx2), .cfg_wdata(cfg_wdata),
    .num_layers(num2), .start_CNN(1'b0), .abort(1'b0), .done_layer(1'b0),
    .start_layer(d2_sl), .done_CNN(d2_dc), .busy(d2_busy), .cfg_err(d2_err),
    .count_layer(d2_cnt), .ifm_size(d2_a), .ifm_channel(d2_b), .kernel_size(d2_c),
    .num_filter(d2_d), .maxpool_mode(d2_e), .maxpool_stride(d2_f), .upsample_mode(d2_g),
    .start_write_addr(d2_h), .start_read_addr(d2_i));

  assign cfg_pack = {start_read_addr, start_write_addr, upsample_mode, maxpool_stride,
                     maxpool_mode, num_filter, kernel_size, ifm_channel, ifm_size};

  typedef struct { int cyc; logic [CW-1:0] cfg; int cnt; } st_t;
  st_t st_q[$];
  int dc_q[$], er_q[$], dl_q[$];
  int cyc = 0, busy_cyc = 0, wr_cyc = -1;
  int n_chk = 0, n_pass = 0;
  logic [CW-1:0] mdl [ML];

  always @(posedge clk) cyc <= cyc + 1;

  // pulse monitor, sampled on the inactive edge
  always @(negedge clk) if (rst_n) begin
    if (start_layer) st_q.push_back('{cyc, cfg_pack, int'(count_layer)});
    if (done_CNN) dc_q.push_back(cyc);
    if (cfg_err) er_q.push_back(cyc);
    if (busy) busy_cyc++;
  end

  task automatic tick; @(posedge clk); #1; endtask

  task automatic clear_mon;
    st_q.delete(); dc_q.delete(); er_q.delete(); dl_q.delete(); busy_cyc = 0; wr_cyc = -1;
  endtask

  function automatic logic [CW-1:0] rnd_cfg();
    return CW'({$urandom(), $urandom(), $urandom()});
  endfunction

  task automatic prog(input int i, input logic [CW-1:0] d);
    cfg_we = 1; cfg_idx = IW'(i); cfg_wdata = d; tick; cfg_we = 0; mdl[i] = d;
  endtask

  // drives one run; the datapath answers done_layer 5 cycles after each start_layer
  task automatic run(input int n, input int abort_at, input bit wr_busy, input bit spur,
                     input bit wr_start, output int e0, output bit tmo);
    int cd, nth; bit ab;
    clear_mon(); cd = -1; nth = 0; ab = 0; tmo = 1;
    num_layers = NW'(n); start_CNN = 1;
    if (spur) done_layer = 1;
    if (wr_start) begin cfg_we = 1; cfg_idx = 0; cfg_wdata = rnd_cfg(); mdl[0] = cfg_wdata; end
    e0 = cyc + 1;
    tick; start_CNN = 0; cfg_we = 0;
    if (spur) tick;
    for (int c = 0; c < 400; c++) begin
      if (done_CNN || (ab && !busy)) begin tmo = 0; break; end
      if (start_layer) begin
        cd = 4;
        if (wr_busy && wr_cyc < 0) begin cfg_we = 1; cfg_idx = 1; cfg_wdata = rnd_cfg(); wr_cyc = cyc; end
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          done_layer = 1; dl_q.push_back(cyc + 1); nth++;
          if (nth == abort_at) begin abort = 1; ab = 1; end
        end
      end
      tick;
      done_layer = 0; abort = 0; cfg_we = 0;
    end
    tick; tick;
  endtask

  task automatic test_reset;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else n_pass++;
    n_chk++; if (start_layer !== 1'b0) $display("FAIL rst_start_layer got %b exp 0", start_layer); else n_pass++;
    n_chk++; if (done_CNN !== 1'b0) $display("FAIL rst_done_CNN got %b exp 0", done_CNN); else n_pass++;
    n_chk++; if (cfg_err !== 1'b0) $display("FAIL rst_cfg_err got %b exp 0", cfg_err); else n_pass++;
    n_chk++; if (count_layer !== '0) $display("FAIL rst_count got %0d exp 0", count_layer); else n_pass++;
    n_chk++; if (cfg_pack !== '0) $display("FAIL rst_cfg got %h exp 0", cfg_pack); else n_pass++;
  endtask

  task automatic test_three_layer;
    int e0; bit tmo;
    for (int i = 0; i < 3; i++) prog(i, rnd_cfg());
    run(3, 0, 0, 0, 0, e0, tmo);
    n_chk++; if (tmo) $display("FAIL three_timeout got timeout exp done"); else n_pass++;
    n_chk++; if (st_q.size() != 3) $display("FAIL three_nstart got %0d exp 3", st_q.size()); else n_pass++;
    n_chk++; if (dc_q.size() != 1) $display("FAIL three_ndone got %0d exp 1", dc_q.size()); else n_pass++;
    for (int i = 0; i < 3 && i < st_q.size() && dl_q.size() >= 3; i++) begin
      n_chk++; if (st_q[i].cnt != i + 1) $display("FAIL three_count%0d got %0d exp %0d", i, st_q[i].cnt, i + 1); else n_pass++;
      n_chk++; if (st_q[i].cfg !== mdl[i]) $display("FAIL three_cfg%0d got %h exp %h", i, st_q[i].cfg, mdl[i]); else n_pass++;
      n_chk++; if (st_q[i].cyc != ((i == 0) ? e0 + 2 : dl_q[i-1] + 2))
        $display("FAIL three_time%0d got %0d exp %0d", i, st_q[i].cyc, (i == 0) ? e0 + 2 : dl_q[i-1] + 2); else n_pass++;
    end
    if (dc_q.size() == 1 && dl_q.size() >= 3) begin
      n_chk++; if (dc_q[0] != dl_q[2]) $display("FAIL three_done_time got %0d exp %0d", dc_q[0], dl_q[2]); else n_pass++;
    end
    n_chk++; if (busy !== 1'b0) $display("FAIL three_busy_end got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_empty;
    int e0; bit tmo;
    run(0, 0, 0, 0, 0, e0, tmo);
    n_chk++; if (st_q.size() != 0) $display("FAIL empty_nstart got %0d exp 0", st_q.size()); else n_pass++;
    n_chk++; if (dc_q.size() != 1 || dc_q[0] != e0) $display("FAIL empty_done got n=%0d exp 1 at %0d", dc_q.size(), e0); else n_pass++;
    n_chk++; if (busy_cyc != 0) $display("FAIL empty_busy got %0d cycles exp 0", busy_cyc); else n_pass++;
  endtask

  task automatic test_clamp;
    int e0; bit tmo;
    for (int i = 0; i < ML; i++) prog(i, rnd_cfg());
    run(ML + 3, 0, 0, 0, 0, e0, tmo);
    n_chk++; if (st_q.size() != ML) $display("FAIL clamp_nstart got %0d exp %0d", st_q.size(), ML); else n_pass++;
    for (int i = 0; i < ML && i < st_q.size(); i++) begin
      n_chk++; if (st_q[i].cfg !== mdl[i] || st_q[i].cnt != i + 1)
        $display("FAIL clamp_layer%0d got %h/%0d exp %h/%0d", i, st_q[i].cfg, st_q[i].cnt, mdl[i], i + 1); else n_pass++;
    end
    n_chk++; if (dc_q.size() != 1) $display("FAIL clamp_ndone got %0d exp 1", dc_q.size()); else n_pass++;
  endtask

  task automatic test_abort;
    int e0; bit tmo;
    run(3, 2, 0, 0, 0, e0, tmo);
    n_chk++; if (tmo) $display("FAIL abort_timeout got timeout exp idle"); else n_pass++;
    n_chk++; if (st_q.size() != 2) $display("FAIL abort_nstart got %0d exp 2", st_q.size()); else n_pass++;
    n_chk++; if (dc_q.size() != 0) $display("FAIL abort_done got %0d exp 0", dc_q.size()); else n_pass++;
    n_chk++; if (count_layer !== '0) $display("FAIL abort_count got %0d exp 0", count_layer); else n_pass++;
    run(3, 0, 0, 0, 0, e0, tmo);
    n_chk++; if (st_q.size() != 3) $display("FAIL restart_nstart got %0d exp 3", st_q.size()); else n_pass++;
    if (st_q.size() > 0) begin
      n_chk++; if (st_q[0].cnt != 1 || st_q[0].cfg !== mdl[0])
        $display("FAIL restart_first got %0d/%h exp 1/%h", st_q[0].cnt, st_q[0].cfg, mdl[0]); else n_pass++;
    end
  endtask

  task automatic test_dropped_writes;
    int e0, wc; bit tmo;
    clear_mon(); prog(3, rnd_cfg()); tick;
    n_chk++; if (er_q.size() != 0) $display("FAIL idle_write_err got %0d exp 0", er_q.size()); else n_pass++;
    run(2, 0, 1, 0, 0, e0, tmo);
    wc = wr_cyc;
    n_chk++; if (er_q.size() != 1 || er_q[0] != wc + 1)
      $display("FAIL busy_write_err got n=%0d exp 1 at %0d", er_q.size(), wc + 1); else n_pass++;
    run(2, 0, 0, 0, 0, e0, tmo);
    n_chk++; if (st_q.size() != 2 || st_q[1].cfg !== mdl[1])
      $display("FAIL busy_write_kept got n=%0d exp entry %h", st_q.size(), mdl[1]); else n_pass++;
    cfg_we2 = 1; cfg_idx2 = 4'd13; cfg_wdata = rnd_cfg(); tick; cfg_we2 = 0;
    n_chk++; if (d2_err !== 1'b1) $display("FAIL oor_write_err got %b exp 1", d2_err); else n_pass++;
    tick;
    n_chk++; if (d2_err !== 1'b0) $display("FAIL oor_err_width got %b exp 0", d2_err); else n_pass++;
    cfg_we2 = 1; cfg_idx2 = 4'd5; tick; cfg_we2 = 0;
    n_chk++; if (d2_err !== 1'b0) $display("FAIL inrange_write_err got %b exp 0", d2_err); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int e0; bit tmo;
    run(2, 0, 0, 1, 1, e0, tmo);
    n_chk++; if (st_q.size() != 2) $display("FAIL b2b_nstart got %0d exp 2", st_q.size()); else n_pass++;
    if (st_q.size() == 2) begin
      n_chk++; if (st_q[0].cfg !== mdl[0]) $display("FAIL b2b_newcfg got %h exp %h", st_q[0].cfg, mdl[0]); else n_pass++;
      n_chk++; if (st_q[0].cyc != e0 + 2) $display("FAIL b2b_time got %0d exp %0d", st_q[0].cyc, e0 + 2); else n_pass++;
      n_chk++; if (st_q[0].cnt != 1 || st_q[1].cnt != 2)
        $display("FAIL spur_count got %0d,%0d exp 1,2", st_q[0].cnt, st_q[1].cnt); else n_pass++;
    end
    n_chk++; if (dc_q.size() != 1) $display("FAIL b2b_ndone got %0d exp 1", dc_q.size()); else n_pass++;
  endtask

  task automatic test_reset_midrun;
    int e0; bit tmo, seen;
    seen = 0; num_layers = 3; start_CNN = 1; tick; start_CNN = 0;
    for (int c = 0; c < 20 && !seen; c++) begin if (start_layer) seen = 1; else tick; end
    n_chk++; if (!seen) $display("FAIL midrun_start got none exp pulse"); else n_pass++;
    tick; tick;
    rst_n = 0; #1;
    n_chk++; if (busy !== 1'b0 || count_layer !== '0) $display("FAIL midrun_rst_state got %b/%0d exp 0/0", busy, count_layer); else n_pass++;
    n_chk++; if (cfg_pack !== '0) $display("FAIL midrun_rst_cfg got %h exp 0", cfg_pack); else n_pass++;
    n_chk++; if (start_layer !== 1'b0 || done_CNN !== 1'b0) $display("FAIL midrun_rst_pulses got %b%b exp 00", start_layer, done_CNN); else n_pass++;
    tick; rst_n = 1; tick;
    for (int i = 0; i < ML; i++) mdl[i] = '0;
    run(1, 0, 0, 0, 0, e0, tmo);
    n_chk++; if (st_q.size() != 1 || st_q[0].cfg !== mdl[0])
      $display("FAIL table_cleared got n=%0d exp 1 zero entry", st_q.size()); else n_pass++;
  endtask

  initial begin
    tick; tick; rst_n = 1; tick;
    test_reset();
    test_three_layer();
    test_empty();
    test_clamp();
    test_abort();
    test_dropped_writes();
    test_back_to_back();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
